// File: rtl/sub_32_seq_if.sv
// Operand/result handshake bundle for the sequential 32-bit subtractor.
// slave is the subtractor side, master is the producer/consumer side.
interface sub_32_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        b_out;
    logic        ovf;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  b_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output b_out,
        output ovf
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output b_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  b_out,
        input  ovf
    );
endinterface

// File: rtl/sub_32_seq.sv
// Byte-serial 32-bit subtractor with borrow in/out and signed overflow flag.
// Latency: result valid 4 cycles after the accept edge; one operation in flight.
// Backpressure: result held in DONE until out_ready; in_ready only while idle.
module sub_32_seq (
    input  logic        clk,
    input  logic        rst,
    sub_32_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        borrow_q;
    logic [31:0] diff_q;
    logic        b_out_q;
    logic        ovf_q;

    logic        accept;
    logic        handshake;
    logic        last_chunk;
    logic [4:0]  byte_lsb;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic [8:0]  byte_res;

    assign accept     = bus.in_valid  && (state_q == IDLE);
    assign handshake  = bus.out_ready && (state_q == DONE);
    assign last_chunk = (state_q == CALC) && (cnt_q == 2'd3);
    assign byte_lsb   = {cnt_q, 3'b000};

    // One byte per CALC cycle; bit 8 of the 9-bit difference is the borrow out.
    always_comb begin
        a_byte   = a_q[byte_lsb +: 8];
        b_byte   = b_q[byte_lsb +: 8];
        byte_res = {1'b0, a_byte} - {1'b0, b_byte} - {8'd0, borrow_q};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = CALC;
            CALC:    if (last_chunk) state_d = DONE;
            DONE:    if (handshake)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            borrow_q <= 1'b0;
            diff_q   <= 32'd0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.b_in;
                        cnt_q    <= 2'd0;
                    end
                end
                CALC: begin
                    diff_q[byte_lsb +: 8] <= byte_res[7:0];
                    borrow_q              <= byte_res[8];
                    cnt_q                 <= cnt_q + 2'd1;
                    if (last_chunk) begin
                        b_out_q <= byte_res[8];
                        // byte_res[7] is the final diff[31]
                        ovf_q   <= (a_q[31] ^ b_q[31]) & (byte_res[7] ^ a_q[31]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.b_out     = b_out_q;
    assign bus.ovf       = ovf_q;
endmodule
